// File: rtl/inport_buffer_if.sv
// Handshake bundle for the datapath input-port feeder: device push side,
// delivery side toward the InPort register and control unit, and FIFO status.
interface inport_buffer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_W     = 2
);
   logic [DATA_WIDTH-1:0] dev_data;
   logic                  dev_valid;
   logic                  dev_ready;
   logic [DATA_WIDTH-1:0] InportData;
   logic                  InPortin;
   logic                  in_valid;
   logic                  cpu_ack;
   logic [ADDR_W:0]       count;
   logic                  in_empty;
   logic                  in_full;

   modport slave (
      input  dev_data, dev_valid, cpu_ack,
      output dev_ready, InportData, InPortin, in_valid, count, in_empty, in_full
   );

   modport master (
      output dev_data, dev_valid, cpu_ack,
      input  dev_ready, InportData, InPortin, in_valid, count, in_empty, in_full
   );
endinterface

// File: rtl/inport_buffer.sv
// Input-port feeder: queues device words in a small FIFO and hands them one at
// a time to the datapath InPort register, holding each until the CPU acks it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | nothing held; pops the FIFO head as soon as count > 0
// ST_LOAD | InPortin strobe cycle, InportData carries the popped word
// ST_HELD | word captured by datapath, in_valid=1 until cpu_ack
module inport_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int ADDR_W     = 2
) (
   input  logic               clk,
   input  logic               reset,
   inport_buffer_if.slave     bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_HELD = 2'd2;

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]     wr_ptr;
   logic [ADDR_W-1:0]     rd_ptr;
   logic [ADDR_W:0]       count_q;
   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  strobe_q;
   logic                  held_q;

   logic full;
   logic empty;
   logic push;
   logic pop;

   assign full  = (count_q == FULL_COUNT);
   assign empty = (count_q == '0);
   assign push  = bus.dev_valid & bus.dev_ready;
   assign pop   = (state == ST_IDLE) & ~empty;

   // Ready only reflects registered occupancy, so a pop frees a slot one cycle later.
   assign bus.dev_ready  = reset & ~full;
   assign bus.InportData = data_q;
   assign bus.InPortin   = strobe_q;
   assign bus.in_valid   = held_q;
   assign bus.count      = count_q;
   assign bus.in_empty   = empty;
   assign bus.in_full    = full;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.dev_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ST_IDLE;
         data_q   <= '0;
         strobe_q <= 1'b0;
         held_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               strobe_q <= 1'b0;
               held_q   <= 1'b0;
               if (pop) begin
                  state    <= ST_LOAD;
                  data_q   <= mem[rd_ptr];
                  strobe_q <= 1'b1;
               end
            end
            ST_LOAD: begin
               state    <= ST_HELD;
               strobe_q <= 1'b0;
               held_q   <= 1'b1;
            end
            ST_HELD: begin
               strobe_q <= 1'b0;
               if (bus.cpu_ack) begin
                  state  <= ST_IDLE;
                  held_q <= 1'b0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               strobe_q <= 1'b0;
               held_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inport_buffer.sv
// Bench for inport_buffer: directed scenarios plus a randomized run, every
// cycle compared against a queue-based model of the delivery rules.
module tb_inport_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic clk = 1'b0;
   logic reset;

   inport_buffer_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

   inport_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model: queued words, whether a strobe or a held word is current, last word shown.
   logic [31:0] q[$];
   logic        strobe;
   logic        holding;
   logic [31:0] last_word;
   logic        model_acc;
   logic        cur_rst;

   logic [31:0] src[$];
   logic [31:0] seen[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic rv, input logic v, input logic [31:0] d, input logic a);
      logic do_pop;
      logic nxt_hold;
      model_acc = 1'b0;
      if (!rv) begin
         q.delete();
         strobe    = 1'b0;
         holding   = 1'b0;
         last_word = '0;
      end else begin
         model_acc = v && (q.size() < DEPTH);
         do_pop    = !strobe && !holding && (q.size() > 0);
         nxt_hold  = strobe || (holding && !a);
         if (do_pop) last_word = q.pop_front();
         if (model_acc) q.push_back(d);
         strobe  = do_pop;
         holding = nxt_hold;
      end
   endtask

   task automatic check_all();
      chk("dev_ready",  32'(bus.dev_ready),  32'(cur_rst && (q.size() < DEPTH)));
      chk("InPortin",   32'(bus.InPortin),   32'(strobe));
      chk("in_valid",   32'(bus.in_valid),   32'(holding));
      chk("InportData", bus.InportData,      last_word);
      chk("count",      32'(bus.count),      32'(q.size()));
      chk("in_empty",   32'(bus.in_empty),   32'(q.size() == 0));
      chk("in_full",    32'(bus.in_full),    32'(q.size() == DEPTH));
      if (bus.InPortin === 1'b1) seen.push_back(bus.InportData);
   endtask

   task automatic cycle(input logic rv, input logic v, input logic [31:0] d, input logic a);
      reset         = rv;
      bus.dev_valid = v;
      bus.dev_data  = d;
      bus.cpu_ack   = a;
      cur_rst       = rv;
      @(posedge clk);
      model_step(rv, v, d, a);
      @(negedge clk);
      check_all();
   endtask

   // ack_mode: 0 never, 1 whenever a word is held, 2 random
   task automatic run(input int n, input int ack_mode);
      for (int i = 0; i < n; i++) begin
         logic v;
         logic a;
         v = (src.size() > 0);
         a = (ack_mode == 1) ? holding : (ack_mode == 2) ? 1'($urandom_range(1)) : 1'b0;
         cycle(1'b1, v, v ? src[0] : 32'd0, a);
         if (model_acc) void'(src.pop_front());
      end
   endtask

   logic [31:0] exp_fill [6];

   initial begin
      strobe    = 1'b0;
      holding   = 1'b0;
      last_word = '0;
      model_acc = 1'b0;
      reset         = 1'b0;
      cur_rst       = 1'b0;
      bus.dev_valid = 1'b0;
      bus.dev_data  = '0;
      bus.cpu_ack   = 1'b0;

      // Reset held two cycles with the device offering a word
      cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      chk("rst_ready", 32'(bus.dev_ready), 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_data",  bus.InportData, 32'd0);
      cycle(1'b1, 1'b0, 32'd0, 1'b0);

      // Single word: push at k, strobe in cycle after k+1, held after k+2
      cycle(1'b1, 1'b1, 32'd16, 1'b0);
      chk("single_cnt", 32'(bus.count), 32'd1);
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
      chk("single_strobe", 32'(bus.InPortin), 32'd1);
      chk("single_data",   bus.InportData, 32'd16);
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
      chk("single_strobe_off", 32'(bus.InPortin), 32'd0);
      chk("single_held",       32'(bus.in_valid), 32'd1);
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
      chk("single_still_held", 32'(bus.in_valid), 32'd1);
      cycle(1'b1, 1'b0, 32'd0, 1'b1);
      chk("single_acked", 32'(bus.in_valid), 32'd0);
      chk("single_empty", 32'(bus.count), 32'd0);
      chk("single_keep",  bus.InportData, 32'd16);

      // Fill and backpressure
      seen.delete();
      for (int w = 16; w <= 21; w++) src.push_back(32'(w));
      run(12, 0);
      chk("fill_count", 32'(bus.count), 32'd4);
      chk("fill_full",  32'(bus.in_full), 32'd1);
      chk("fill_ready", 32'(bus.dev_ready), 32'd0);
      chk("fill_pend",  32'(src.size()), 32'd1);
      run(25, 1);
      exp_fill = '{32'd16, 32'd17, 32'd18, 32'd19, 32'd20, 32'd21};
      chk("fill_nseen", 32'(seen.size()), 32'd6);
      for (int i = 0; i < 6; i++) chk("fill_order", seen[i], exp_fill[i]);

      // Simultaneous push and pop on the LOAD-entry edge
      run(4, 1);
      seen.delete();
      src.push_back(32'h11);
      src.push_back(32'hA5);
      run(1, 0);
      run(1, 0);
      chk("sim_count", 32'(bus.count), 32'd1);
      chk("sim_strobe", 32'(bus.InPortin), 32'd1);
      run(15, 1);
      chk("sim_nseen", 32'(seen.size()), 32'd2);
      chk("sim_first", seen[0], 32'h11);
      chk("sim_second", seen[1], 32'hA5);

      // Stray ack while idle and empty
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0, 1'b1);
      chk("stray_valid", 32'(bus.in_valid), 32'd0);
      seen.delete();
      src.push_back(32'd15);
      run(8, 0);
      chk("stray_nseen", 32'(seen.size()), 32'd1);
      chk("stray_word", seen[0], 32'd15);
      run(2, 1);

      // Reset while a word is held and two are queued
      src.push_back(32'd1);
      src.push_back(32'd2);
      src.push_back(32'd3);
      run(10, 0);
      chk("mid_count", 32'(bus.count), 32'd2);
      chk("mid_held",  32'(bus.in_valid), 32'd1);
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      chk("mid_rst_count", 32'(bus.count), 32'd0);
      chk("mid_rst_valid", 32'(bus.in_valid), 32'd0);
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
      chk("mid_no_strobe", 32'(bus.InPortin), 32'd0);
      seen.delete();
      src.push_back(32'd7);
      run(8, 0);
      chk("mid_first", seen[0], 32'd7);
      run(3, 1);

      // Randomized traffic with random acks, gaps and rare resets
      for (int i = 0; i < 600; i++) begin
         logic rv;
         logic v;
         logic a;
         if (src.size() < 2 && $urandom_range(99) < 60) src.push_back($urandom);
         rv = ($urandom_range(199) != 0);
         v  = (src.size() > 0) && ($urandom_range(99) < 70);
         a  = ($urandom_range(99) < 40);
         cycle(rv, v, v ? src[0] : 32'd0, a);
         if (model_acc) void'(src.pop_front());
      end
      run(40, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/inport_buffer.md
# inport_buffer

Upstream feeder for the datapath input port. It accepts words from an external device over a valid/ready handshake and queues them in a DEPTH-entry FIFO. It presents one word at a time on `InportData`, with a one-cycle `InPortin` load strobe, so the datapath InPort register captures it. It holds that word until the control unit acknowledges consumption (the `in` instruction's InPortout step).

## Interface

Parameters:
- DATA_WIDTH, 32, word width (matches datapath bus)
- DEPTH, 4, FIFO entries; power of two, ≥2
- ADDR_W, 2, log2(DEPTH)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  one clock; reset is synchronous and active-low (asserted when 0, sampled on rising clk)
- dev_data  in  DATA_WIDTH  device word
- dev_valid  in  1  device offers dev_data
- dev_ready  out  1  buffer accepts; push occurs when dev_valid & dev_ready at rising edge
- InportData  out  DATA_WIDTH  word to datapath InPort register, registered
- InPortin  out  1  load strobe to datapath InPort register, registered, one cycle per word
- in_valid  out  1  a delivered word is held awaiting consumption
- cpu_ack  in  1  control unit has consumed the held word
- count  out  ADDR_W+1  FIFO occupancy 0..DEPTH (excludes held word)
- in_empty  out  1  count == 0
- in_full  out  1  count == DEPTH

## Operation

- FIFO: mem[DEPTH], wr_ptr/rd_ptr ADDR_W bits, wrap modulo DEPTH naturally; count tracked separately.
- dev_ready = reset & ~in_full (combinational from registered count). Forced 0 while reset low.
- Push: dev_valid & dev_ready → mem[wr_ptr] ← dev_data, wr_ptr+1, count+1.
- Delivery FSM, 3 states:
  - IDLE: InPortin=0, in_valid=0. count>0 → LOAD.
  - LOAD: on entry edge, InportData ← mem[rd_ptr] and InPortin ← 1. Pop on same edge: rd_ptr+1, count−1. Next → HELD.
  - HELD: InPortin=0, in_valid=1, InportData stable. cpu_ack → IDLE, in_valid ← 0. Otherwise remain.
- InPortin and InportData are registered outputs. InPortin is high exactly the one cycle the FSM is in LOAD.
- Capacity: DEPTH queued words plus 1 held word.
- cpu_ack outside HELD is ignored; it does not pop and does not change state.
- Simultaneous push and pop (LOAD-entry edge with push): count unchanged, both pointers advance, data integrity preserved. When full, push is impossible because dev_ready=0. A pop that same edge raises dev_ready the next cycle, not the same cycle.
- Order strictly FIFO. No word is dropped or duplicated.
- InportData retains the last delivered word after HELD→IDLE until the next LOAD.

## Timing

- Reset (reset=0 at rising edge): state IDLE, wr_ptr=rd_ptr=0, count=0, InportData=0, InPortin=0, in_valid=0. Outputs read in_empty=1, in_full=0, dev_ready=0. Mem contents don't-care.
- Reset mid-operation clears queued and held words. The next cycle has no InPortin pulse even if one was pending.
- Latency: push at edge k into an empty buffer with FSM in IDLE → count=1 after k. The IDLE→LOAD transition occurs at edge k+1, where InPortin rises and InportData is valid. The datapath captures at edge k+2, and in_valid rises after edge k+2.
- Throughput: cpu_ack sampled at edge a in HELD → IDLE after a, LOAD after a+1. Minimum 3 cycles per delivered word.
- cpu_ack may arrive the first HELD cycle.

## Test plan

- Reset: hold reset=0 two cycles with dev_valid=1 → dev_ready=0, count=0, InPortin=0, InportData=0, no push.
- Single word: push 32'd16 at edge k → InPortin=1 exactly during cycle after k+1, InportData=16. Then in_valid=1 and held until cpu_ack, after which in_valid=0 and count=0.
- Fill and backpressure: no cpu_ack, push 16,17,18,19,20,21 back to back → first word delivered and held. Count reaches 4 (words 17..20), in_full=1, dev_ready=0, word 21 held off by device. Then ack four times → delivered order 17,18,19,20, then 21 accepted.
- Simultaneous push/pop: count=1 with FSM in IDLE, push 32'hA5 on the LOAD-entry edge → count stays 1, pointers advance. Subsequent deliveries are in order with wrap past rd_ptr=3→0.
- Stray ack: pulse cpu_ack while in IDLE with empty FIFO, then push 15 → no state change from the ack, and 15 is delivered normally.
- Reset mid-HELD with 2 queued → after reset, count=0, in_valid=0, InPortin stays 0, and the next push is delivered as first word.
